// File: rtl/fifo_wside_ctrl_if.sv
// Write-side bundle of the dual-clock FIFO: request/pointer inputs from the producer
// and read domain, status and RAM-control outputs back from the write-side controller.
interface fifo_wside_ctrl_if #(
   parameter int ASIZE = 4
);
   // winc is a request with no ready of its own: a write commits on the wclk edge where
   // wen (= winc & ~wfull) is high; a request seen while wfull is high is dropped and flagged.
   logic             winc;
   logic [ASIZE:0]   rptr;
   logic [ASIZE:0]   afull_thresh;
   logic             clr_err;
   logic [ASIZE:0]   wptr;
   logic [ASIZE-1:0] waddr;
   logic             wen;
   logic             wfull;
   logic             walmost_full;
   logic [ASIZE:0]   wlevel;
   logic             gray_err;
   logic             wovf;

   modport master (
      output winc, rptr, afull_thresh, clr_err,
      input  wptr, waddr, wen, wfull, walmost_full, wlevel, gray_err, wovf
   );

   modport slave (
      input  winc, rptr, afull_thresh, clr_err,
      output wptr, waddr, wen, wfull, walmost_full, wlevel, gray_err, wovf
   );
endinterface

// File: rtl/fifo_wside_ctrl.sv
// Write-side controller of the dual-clock FIFO: read-pointer synchroniser, write pointer,
// full / almost-full / level generation, plus sticky Gray-integrity and overflow debug flags.
module fifo_wside_ctrl #(
   parameter int ASIZE       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CHECK_GRAY  = 1
) (
   input logic              wclk,
   input logic              wrst_n,
   fifo_wside_ctrl_if.slave bus
);
   localparam logic [ASIZE:0] ONE = {{ASIZE{1'b0}}, 1'b1};

   logic [ASIZE:0] r_sync [SYNC_STAGES];
   logic [ASIZE:0] r_wbin;
   logic [ASIZE:0] r_wptr;
   logic           r_wfull;
   logic           r_walmost_full;
   logic [ASIZE:0] r_wlevel;
   logic [ASIZE:0] r_prev_rptr;
   logic           r_gray_err;
   logic           r_wovf;

   logic [ASIZE:0] w_wq_rptr;
   logic [ASIZE:0] w_wq_rbin;
   logic           w_wen;
   logic [ASIZE:0] w_wbin_next;
   logic [ASIZE:0] w_wgray_next;
   logic           w_full_next;
   logic [ASIZE:0] w_level_next;
   logic           w_afull_next;
   logic [ASIZE:0] w_gdiff;
   logic           w_gray_evt;
   logic           w_ovf_evt;

   // Plain flop chain into wclk; nothing may sit between stages.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= bus.rptr;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_wq_rptr = r_sync[SYNC_STAGES-1];

   // Binary bit i is the parity of all Gray bits from i up to the MSB.
   always_comb begin
      w_wq_rbin = '0;
      for (int i = 0; i <= ASIZE; i++) w_wq_rbin[i] = ^(w_wq_rptr >> i);
   end

   assign w_wen        = bus.winc & ~r_wfull;
   assign w_wbin_next  = r_wbin + {{ASIZE{1'b0}}, w_wen};
   assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
   assign w_full_next  = (w_wgray_next == {~w_wq_rptr[ASIZE:ASIZE-1], w_wq_rptr[ASIZE-2:0]});
   assign w_level_next = w_wbin_next - w_wq_rbin;
   assign w_afull_next = (w_level_next >= bus.afull_thresh);
   assign w_ovf_evt    = bus.winc & r_wfull;

   // More than one bit set in the sample-to-sample difference means a non-Gray step.
   assign w_gdiff    = w_wq_rptr ^ r_prev_rptr;
   assign w_gray_evt = (CHECK_GRAY != 0) && (|(w_gdiff & (w_gdiff - ONE)));

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_wbin         <= '0;
         r_wptr         <= '0;
         r_wfull        <= 1'b0;
         r_walmost_full <= 1'b0;
         r_wlevel       <= '0;
         r_prev_rptr    <= '0;
         r_gray_err     <= 1'b0;
         r_wovf         <= 1'b0;
      end else begin
         r_wbin         <= w_wbin_next;
         r_wptr         <= w_wgray_next;
         r_wfull        <= w_full_next;
         r_walmost_full <= w_afull_next;
         r_wlevel       <= w_level_next;
         r_prev_rptr    <= w_wq_rptr;
         // A fresh error event outranks a clear arriving on the same edge.
         if (w_gray_evt)       r_gray_err <= 1'b1;
         else if (bus.clr_err) r_gray_err <= 1'b0;
         if (w_ovf_evt)        r_wovf     <= 1'b1;
         else if (bus.clr_err) r_wovf     <= 1'b0;
      end
   end

   assign bus.wptr         = r_wptr;
   assign bus.waddr        = r_wbin[ASIZE-1:0];
   assign bus.wen          = w_wen;
   assign bus.wfull        = r_wfull;
   assign bus.walmost_full = r_walmost_full;
   assign bus.wlevel       = r_wlevel;
   assign bus.gray_err     = r_gray_err;
   assign bus.wovf         = r_wovf;
endmodule

// File: tb/tb_fifo_wside_ctrl.sv
// Bench for fifo_wside_ctrl: two instances (2-stage sync with Gray checker, 3-stage sync
// without) share one stimulus stream and are compared against a count-based reference model.
module tb_fifo_wside_ctrl;
   localparam int S_A = 2;
   localparam int S_B = 3;

   logic       wclk = 1'b0;
   logic       wrst_n;
   logic       winc;
   logic [4:0] rptr;
   logic [4:0] afull_thresh;
   logic       clr_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, index 0 = instance A, 1 = instance B.
   int         m_wtot  [2];
   logic [4:0] m_level [2];
   logic       m_full  [2];
   logic       m_afull [2];
   logic       m_gerr  [2];
   logic       m_ovf   [2];
   logic [4:0] hist[$];

   fifo_wside_ctrl_if #(.ASIZE(4)) if_a ();
   fifo_wside_ctrl_if #(.ASIZE(4)) if_b ();

   assign if_a.winc = winc;  assign if_a.rptr = rptr;
   assign if_a.afull_thresh = afull_thresh;  assign if_a.clr_err = clr_err;
   assign if_b.winc = winc;  assign if_b.rptr = rptr;
   assign if_b.afull_thresh = afull_thresh;  assign if_b.clr_err = clr_err;

   fifo_wside_ctrl #(.ASIZE(4), .SYNC_STAGES(S_A), .CHECK_GRAY(1)) u_dut_a (
      .wclk(wclk), .wrst_n(wrst_n), .bus(if_a));
   fifo_wside_ctrl #(.ASIZE(4), .SYNC_STAGES(S_B), .CHECK_GRAY(0)) u_dut_b (
      .wclk(wclk), .wrst_n(wrst_n), .bus(if_b));

   always #5 wclk = ~wclk;

   function automatic logic [4:0] gray5(int v);
      logic [4:0] b;
      b = 5'(v);
      return b ^ (b >> 1);
   endfunction

   // Inverse Gray by search: the binary value whose Gray code matches.
   function automatic logic [4:0] g2b(logic [4:0] g);
      for (int v = 0; v < 32; v++) if (gray5(v) == g) return 5'(v);
      return 5'd0;
   endfunction

   function automatic logic [4:0] hist_at(int i);
      if (i < hist.size()) return hist[i];
      return 5'd0;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_wtot[k] = 0; m_level[k] = '0; m_full[k] = 1'b0;
         m_afull[k] = 1'b0; m_gerr[k] = 1'b0; m_ovf[k] = 1'b0;
      end
      hist.delete();
   endtask

   // hist[j] is the rptr sampled j+1 edges ago, so an S-stage sync shows hist[S-1].
   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         int s;
         logic [4:0] wq, wq_prev;
         s = (k == 0) ? S_A : S_B;
         wq = hist_at(s - 1);
         wq_prev = hist_at(s);
         if (winc && m_full[k]) begin
            m_ovf[k] = 1'b1;
         end else begin
            if (winc) m_wtot[k]++;
            if (clr_err) m_ovf[k] = 1'b0;
         end
         m_level[k] = 5'(m_wtot[k]) - g2b(wq);
         m_full[k]  = (m_level[k] == 5'd16);
         m_afull[k] = (int'(m_level[k]) >= int'(afull_thresh));
         if (k == 0 && $countones(wq ^ wq_prev) > 1) m_gerr[k] = 1'b1;
         else if (clr_err) m_gerr[k] = 1'b0;
      end
      hist.push_front(rptr);
      if (hist.size() > 8) void'(hist.pop_back());
   endtask

   task automatic step();
      @(posedge wclk);
      model_update();
      @(negedge wclk);
   endtask

   task automatic do_reset();
      wrst_n = 1'b0; winc = 1'b0; clr_err = 1'b0; rptr = '0;
      model_clear();
      repeat (2) @(negedge wclk);
      wrst_n = 1'b1;
   endtask

   task automatic test_reset();
      afull_thresh = 5'd0;
      do_reset();
      n_tests++;
      if ({if_a.wptr, if_a.waddr, if_a.wfull, if_a.walmost_full, if_a.wlevel, if_a.gray_err, if_a.wovf} !== '0) begin
         $display("FAIL reset_a: got wptr=%b waddr=%h full=%b af=%b lvl=%0d gerr=%b ovf=%b exp all 0", if_a.wptr, if_a.waddr, if_a.wfull, if_a.walmost_full, if_a.wlevel, if_a.gray_err, if_a.wovf);
         n_fail++;
      end
      n_tests++;
      if ({if_b.wptr, if_b.waddr, if_b.wfull, if_b.walmost_full, if_b.wlevel, if_b.gray_err, if_b.wovf} !== '0) begin
         $display("FAIL reset_b: got wptr=%b lvl=%0d exp all 0", if_b.wptr, if_b.wlevel);
         n_fail++;
      end
      step();
      n_tests++;
      if (if_a.walmost_full !== 1'b1) begin
         $display("FAIL afull_thresh0: got %b exp 1", if_a.walmost_full); n_fail++;
      end
      winc = 1'b1;
      repeat (5) step();
      winc = 1'b0;
      n_tests++;
      if (if_a.wptr !== 5'b00111 || if_a.wlevel !== 5'd5) begin
         $display("FAIL pre_reset_ptr: got wptr=%b lvl=%0d exp 00111/5", if_a.wptr, if_a.wlevel); n_fail++;
      end
      #2 wrst_n = 1'b0;
      #1;
      n_tests++;
      if ({if_a.wptr, if_a.waddr, if_a.wen, if_a.wfull, if_a.walmost_full, if_a.wlevel, if_a.gray_err, if_a.wovf} !== '0) begin
         $display("FAIL async_reset: got wptr=%b waddr=%h af=%b lvl=%0d exp all 0", if_a.wptr, if_a.waddr, if_a.walmost_full, if_a.wlevel); n_fail++;
      end
      model_clear();
      @(negedge wclk);
      wrst_n = 1'b1;
      n_tests++;
      if (if_a.wptr !== 5'd0 || if_a.waddr !== 4'd0) begin
         $display("FAIL post_reset_ptr: got wptr=%b waddr=%h exp 0/0", if_a.wptr, if_a.waddr); n_fail++;
      end
   endtask

   task automatic test_fill();
      afull_thresh = 5'd12;
      do_reset();
      winc = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         n_tests++;
         if (if_a.wlevel !== 5'(i) || if_a.walmost_full !== (i >= 12)) begin
            $display("FAIL fill_level_%0d: got lvl=%0d af=%b exp %0d/%b", i, if_a.wlevel, if_a.walmost_full, i, (i >= 12)); n_fail++;
         end
      end
      n_tests++;
      if (if_a.wfull !== 1'b1 || if_a.wptr !== 5'b11000 || if_a.wen !== 1'b0) begin
         $display("FAIL fill_full: got full=%b wptr=%b wen=%b exp 1/11000/0", if_a.wfull, if_a.wptr, if_a.wen); n_fail++;
      end
      step();
      n_tests++;
      if (if_a.wptr !== 5'b11000 || if_a.wovf !== 1'b1 || if_b.wovf !== 1'b1) begin
         $display("FAIL overflow: got wptr=%b ovf_a=%b ovf_b=%b exp 11000/1/1", if_a.wptr, if_a.wovf, if_b.wovf); n_fail++;
      end
      winc = 1'b0; clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      n_tests++;
      if (if_a.wovf !== 1'b0 || if_a.wfull !== 1'b1) begin
         $display("FAIL clr_ovf: got ovf=%b full=%b exp 0/1", if_a.wovf, if_a.wfull); n_fail++;
      end
   endtask

   task automatic test_drain();
      afull_thresh = 5'd17;
      do_reset();
      winc = 1'b1;
      repeat (16) step();
      winc = 1'b0;
      n_tests++;
      if (if_a.wfull !== 1'b1 || if_b.wfull !== 1'b1 || if_a.walmost_full !== 1'b0) begin
         $display("FAIL drain_start: got full_a=%b full_b=%b af=%b exp 1/1/0", if_a.wfull, if_b.wfull, if_a.walmost_full); n_fail++;
      end
      rptr = 5'b00001;
      step(); step();
      n_tests++;
      if (if_a.wfull !== 1'b1 || if_b.wfull !== 1'b1) begin
         $display("FAIL drain_e1: got full_a=%b full_b=%b exp 1/1", if_a.wfull, if_b.wfull); n_fail++;
      end
      step();
      n_tests++;
      if (if_a.wfull !== 1'b0 || if_a.wlevel !== 5'd15 || if_b.wfull !== 1'b1) begin
         $display("FAIL drain_e2: got full_a=%b lvl_a=%0d full_b=%b exp 0/15/1", if_a.wfull, if_a.wlevel, if_b.wfull); n_fail++;
      end
      step();
      n_tests++;
      if (if_b.wfull !== 1'b0 || if_b.wlevel !== 5'd15) begin
         $display("FAIL drain_e3: got full_b=%b lvl_b=%0d exp 0/15", if_b.wfull, if_b.wlevel); n_fail++;
      end
   endtask

   task automatic test_wrap();
      int wtot;
      afull_thresh = 5'd12;
      do_reset();
      winc = 1'b1;
      wtot = 0;
      for (int i = 0; i < 40; i++) begin
         rptr = gray5((wtot >= 3) ? wtot - 3 : 0);
         step();
         wtot++;
         n_tests++;
         if (if_a.wptr !== gray5(wtot) || if_a.waddr !== 4'(wtot) || if_a.gray_err !== 1'b0) begin
            $display("FAIL wrap_ptr_%0d: got wptr=%b waddr=%h gerr=%b exp %b/%h/0", i, if_a.wptr, if_a.waddr, if_a.gray_err, gray5(wtot), 4'(wtot)); n_fail++;
         end
         if (i >= 10) begin
            n_tests++;
            if (if_a.wlevel !== 5'd6 || if_b.wlevel !== 5'd7 || if_a.wfull !== 1'b0) begin
               $display("FAIL wrap_level_%0d: got lvl_a=%0d lvl_b=%0d full=%b exp 6/7/0", i, if_a.wlevel, if_b.wlevel, if_a.wfull); n_fail++;
            end
         end
      end
      winc = 1'b0;
   endtask

   task automatic test_gray_fault();
      afull_thresh = 5'd12;
      do_reset();
      step(); step();
      rptr = 5'b00011;
      step(); step();
      n_tests++;
      if (if_a.gray_err !== 1'b0) begin
         $display("FAIL gray_early: got %b exp 0", if_a.gray_err); n_fail++;
      end
      step();
      n_tests++;
      if (if_a.gray_err !== 1'b1 || if_b.gray_err !== 1'b0) begin
         $display("FAIL gray_detect: got a=%b b=%b exp 1/0", if_a.gray_err, if_b.gray_err); n_fail++;
      end
      repeat (3) step();
      n_tests++;
      if (if_a.gray_err !== 1'b1) begin
         $display("FAIL gray_sticky: got %b exp 1", if_a.gray_err); n_fail++;
      end
      rptr = 5'b00000;
      step(); step();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      n_tests++;
      if (if_a.gray_err !== 1'b1 || m_gerr[0] !== 1'b1) begin
         $display("FAIL gray_evt_wins: got %b exp 1", if_a.gray_err); n_fail++;
      end
      step();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      n_tests++;
      if (if_a.gray_err !== 1'b0 || if_b.gray_err !== 1'b0) begin
         $display("FAIL gray_clr: got a=%b b=%b exp 0/0", if_a.gray_err, if_b.gray_err); n_fail++;
      end
   endtask

   task automatic test_random(int cycles);
      int rd_tot;
      afull_thresh = 5'($urandom_range(0, 17));
      do_reset();
      rd_tot = 0;
      for (int i = 0; i < cycles; i++) begin
         winc = ($urandom_range(0, 3) != 0) ^ (i >= cycles / 2 && $urandom_range(0, 1) == 0);
         clr_err = ($urandom_range(0, 15) == 0);
         if (rd_tot < m_wtot[0] && rd_tot < m_wtot[1] && $urandom_range(0, 2) == 0) rd_tot++;
         rptr = gray5(rd_tot);
         step();
         n_tests++;
         if ({if_a.wptr, if_a.waddr, if_a.wfull, if_a.walmost_full, if_a.wlevel, if_a.gray_err, if_a.wovf} !==
             {gray5(m_wtot[0]), 4'(m_wtot[0]), m_full[0], m_afull[0], m_level[0], m_gerr[0], m_ovf[0]}) begin
            $display("FAIL rand_a_%0d: got wptr=%b full=%b af=%b lvl=%0d ovf=%b exp %b/%b/%b/%0d/%b", i, if_a.wptr, if_a.wfull, if_a.walmost_full, if_a.wlevel, if_a.wovf, gray5(m_wtot[0]), m_full[0], m_afull[0], m_level[0], m_ovf[0]); n_fail++;
         end
         n_tests++;
         if ({if_b.wptr, if_b.waddr, if_b.wfull, if_b.walmost_full, if_b.wlevel, if_b.gray_err, if_b.wovf} !==
             {gray5(m_wtot[1]), 4'(m_wtot[1]), m_full[1], m_afull[1], m_level[1], m_gerr[1], m_ovf[1]}) begin
            $display("FAIL rand_b_%0d: got wptr=%b full=%b af=%b lvl=%0d ovf=%b exp %b/%b/%b/%0d/%b", i, if_b.wptr, if_b.wfull, if_b.walmost_full, if_b.wlevel, if_b.wovf, gray5(m_wtot[1]), m_full[1], m_afull[1], m_level[1], m_ovf[1]); n_fail++;
         end
      end
      winc = 1'b0; clr_err = 1'b0;
   endtask

   initial begin
      wrst_n = 1'b0; winc = 1'b0; rptr = '0; afull_thresh = '0; clr_err = 1'b0;
      model_clear();
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_gray_fault();
      test_random(300);
      test_random(300);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
